// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg -- shared definitions for the sequential shift-add multiplier.
//   N_DEFAULT : default operand width (product is 2*N_DEFAULT bits)
//   state_t   : controller state encoding
package seq_mult_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mult_ctrl_if.sv
// seq_mult_ctrl_if -- request/result bundle of the sequential multiplier.
//   start        : begin a multiply (sampled only while ready)
//   multiplicand : operand A, N bits
//   multiplier   : operand B, N bits
//   ready        : controller idle, can accept
//   busy         : operation in progress (CALC or DONE)
//   done         : one-cycle pulse, product valid
//   product      : 2N-bit result, held between operations
// master = requester, slave = multiplier controller.
interface seq_mult_ctrl_if #(
    parameter int N = seq_mult_pkg::N_DEFAULT
);
    logic             start;
    logic [N-1:0]     multiplicand;
    logic [N-1:0]     multiplier;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   product;

    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
endinterface

// File: rtl/seq_mult_ctrl_addn.sv
// addn -- N-bit ripple-carry adder.
//   a, b : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out
module addn #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);
    logic [N:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[N];
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl -- unsigned shift-add multiplier controller, one partial
// product per cycle, N cycles per multiply plus one DONE cycle.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_mult_ctrl_if slave (start/operands in, ready/busy/done/product out)
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_mult_ctrl_if.slave bus
);
    localparam int CW = $clog2(N + 1);

    state_t          state, state_nx;
    logic [N-1:0]    a_r, q_r, p_r;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    addend, sum;
    logic            cout;
    logic            last;

    assign addend = q_r[0] ? a_r : '0;
    assign last   = (cnt == CW'(N - 1));

    addn #(.N(N)) u_addn (
        .a    (p_r),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        bus.ready = 1'b0;
        bus.busy  = 1'b0;
        case (state)
            IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) state_nx = CALC;
            end
            CALC: begin
                bus.busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                bus.busy = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The adder carry is shifted into P in the same cycle it is produced, so
    // {C,P,Q} >> 1 reduces to P <= {cout,sum[N-1:1]}, Q <= {sum[0],Q[N-1:1]}
    // and C never needs its own flop. The final product is taken from these
    // shifted values directly so it lands on the DONE-entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            q_r         <= '0;
            p_r         <= '0;
            cnt         <= '0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_r <= bus.multiplicand;
                        q_r <= bus.multiplier;
                        p_r <= '0;
                        cnt <= '0;
                    end
                end
                CALC: begin
                    p_r <= {cout, sum[N-1:1]};
                    q_r <= {sum[0], q_r[N-1:1]};
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        bus.product <= {cout, sum, q_r[N-1:1]};
                        bus.done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl -- directed self-checking bench for seq_mult_ctrl (N=4).
module tb_seq_mult_ctrl;
    localparam int N = 4;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   done_seen = 0;

    seq_mult_ctrl_if #(.N(N)) bus ();

    seq_mult_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // done pulse counter, sampled shortly after each rising edge
    always @(posedge clk) begin
        #2;
        if (bus.done === 1'b1) done_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one multiply from IDLE; check latency, product, single pulse, return to ready.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [7:0] exp);
        int lat;
        int d0;
        @(negedge clk);
        d0 = done_seen;
        bus.multiplicand = a;
        bus.multiplier   = b;
        bus.start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_busy"}, bus.busy, 1);
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        check({tag, "_lat"}, lat, 4);
        check({tag, "_prod"}, bus.product, exp);
        @(negedge clk);
        check({tag, "_ready"}, bus.ready, 1);
        check({tag, "_done0"}, bus.done, 0);
        check({tag, "_pulses"}, done_seen - d0, 1);
    endtask

    initial begin
        int d0;
        int cyc;
        int ndone;
        int dpos[8];
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_prod", bus.product, 0);
        rst_n = 1'b1;

        run_op("max", 4'd15, 4'd15, 8'hE1);
        run_op("mix", 4'd13, 4'd11, 8'd143);
        run_op("zA", 4'd0, 4'd9, 8'd0);
        run_op("zB", 4'd9, 4'd0, 8'd0);
        run_op("one", 4'd1, 4'd15, 8'd15);

        // start and new operands during CALC must be ignored
        @(negedge clk);
        d0 = done_seen;
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd6;
        bus.start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.multiplicand = 4'd2;
        bus.multiplier   = 4'd3;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        check("busy_prod", bus.product, 42);
        repeat (8) @(negedge clk);
        check("busy_pulses", done_seen - d0, 1);
        check("busy_hold", bus.product, 42);
        check("busy_ready", bus.ready, 1);

        // continuous start: one result every 6 cycles
        bus.multiplicand = 4'd5;
        bus.multiplier   = 4'd5;
        bus.start        = 1'b1;
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 && ndone < 8) begin
                dpos[ndone] = i;
                ndone++;
                check("cont_prod", bus.product, 25);
            end
        end
        bus.start = 1'b0;
        check("cont_count", ndone, 4);
        if (ndone >= 3) begin
            check("cont_gap1", dpos[1] - dpos[0], 6);
            check("cont_gap2", dpos[2] - dpos[1], 6);
        end
        cyc = 0;
        while (bus.ready !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        check("cont_idle", bus.ready, 1);

        // reset during the second CALC cycle of 12 x 12
        @(negedge clk);
        d0 = done_seen;
        bus.multiplicand = 4'd12;
        bus.multiplier   = 4'd12;
        bus.start        = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_ready", bus.ready, 1);
        check("mid_busy", bus.busy, 0);
        check("mid_done", bus.done, 0);
        check("mid_prod", bus.product, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("mid_nopulse", done_seen - d0, 0);
        check("mid_prod2", bus.product, 0);
        run_op("post", 4'd3, 4'd4, 8'd12);

        // product held while idle with operands toggling
        run_op("hold", 4'd6, 4'd7, 8'd42);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.multiplicand = 4'(i);
            bus.multiplier   = ~4'(i);
            check("hold_prod", bus.product, 42);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter: N, default 4, operand width in bits; the product is 2N bits wide.
REQ-002 Port: clk, input, 1, sole clock; all state updates on the rising edge.
REQ-003 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port: start, input, 1, request to begin a multiply; sampled only while ready=1.
REQ-005 Port: multiplicand, input, N, operand A; captured on the accepting edge.
REQ-006 Port: multiplier, input, N, operand B; captured on the accepting edge.
REQ-007 Port: ready, output, 1, high only in IDLE.
REQ-008 Port: busy, output, 1, high in CALC and DONE.
REQ-009 Port: done, output, 1, registered one-cycle pulse marking a valid product.
REQ-010 Port: product, output, 2N, result register; held between operations.

Function
REQ-011 The FSM SHALL have states IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-012 In IDLE with start=1, the next edge SHALL latch A=multiplicand and Q=multiplier, clear accumulator P (N bits) and carry C, clear the iteration counter, and enter CALC.
REQ-013 Each CALC cycle SHALL form {C,P} = P + (Q[0] ? A : 0) through the N-bit adder sub-module, with carry-in 0.
REQ-014 On the same edge it SHALL shift right: {C,P,Q} <= {0,C,P,Q} >> 1, then increment the counter.
REQ-015 After exactly N CALC cycles, the FSM SHALL enter DONE, load product <= {P,Q}, and assert done.
REQ-016 Latency: with accept on edge k, done and the new product SHALL be visible after edge k+N; with N=4 that is edge k+4.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE, where ready=1 and done=0.
REQ-018 start SHALL be ignored in CALC and DONE; operand changes after the accepting edge SHALL have no effect.
REQ-019 If start is held high continuously, a new operation SHALL be accepted on the first IDLE edge, so one operation completes every N+2 cycles.
REQ-020 product SHALL change only on DONE entry or reset.
REQ-021 Arithmetic SHALL be unsigned; the full 2N-bit result SHALL be exact and never truncated.
REQ-022 The counter SHALL be sized to reach N without wrap.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force state=IDLE, ready=1, busy=0, done=0, product=0, and A, Q, P, C and the counter to 0.
REQ-024 Reset asserted mid-CALC or in DONE SHALL abort the operation with no done pulse.
REQ-025 After reset release, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-026 Package seq_mult_pkg SHALL hold the state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10) and the default width constant N.
REQ-027 The N-bit ripple adder SHALL be a separate sub-module, addn (inputs a, b, cin; outputs sum, cout), instantiated once.
REQ-028 All other logic (FSM, counter, shift register, product register) SHALL reside in seq_mult_ctrl.

Verification
REQ-029 Max operands: 15 x 15 with start pulsed for one cycle -> done exactly 4 edges after accept, product=8'hE1 (225), ready back high the next cycle.
REQ-030 Mixed and zero operands: 13 x 11 -> product=143; 0 x 9 -> 0; 9 x 0 -> 0; 1 x 15 -> 15.
REQ-031 Busy-time stimulus: start=1 and new operands (2 x 3) during CALC of 7 x 6 -> product=42, a single done pulse, 2 x 3 not executed.
REQ-032 Continuous start with operands fixed at 5 x 5 -> done every 6 cycles, product=25 each time.
REQ-033 Reset mid-operation: rst_n low at the 2nd CALC cycle of 12 x 12 -> all outputs at reset values immediately, no done pulse; a subsequent 3 x 4 gives 12.
REQ-034 Hold behaviour: after 6 x 7 -> product stays 42 through 20 idle cycles with operand inputs toggling.
